async_fifo_rd_ctrl: RTL and testbench

- Read-domain controller for the async FIFO: the consumer end of the write-side pointer protocol.
- Synchronises the write-side Gray pointer into rd_clk and drives the synchronous-read memory port.
- Presents data first-word-fall-through on a valid/ready interface through a 2-entry output buffer.
- Returns the registered Gray read pointer to the write domain and reports fill level plus almost-empty.

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/async_fifo_rd_ctrl_if.sv | 20 ++
 rtl/ptr_sync.sv | 24 ++
 rtl/async_fifo_rd_ctrl.sv | 128 ++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for both clock-domain halves of the async FIFO.
// Gray/binary helpers operate on a 32-bit container; callers size-cast results.
package async_fifo_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_PTR_WIDTH = 4;

    typedef logic [31:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended input keeps the upper bits 0, so a full-width prefix XOR is exact.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// First-word-fall-through valid/ready stream presented by the FIFO read side.
interface async_fifo_rd_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ptr_sync.sv
// Multi-bit flop synchroniser for Gray-coded pointers; shared by both FIFO domains.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller: syncs the write pointer, issues synchronous memory reads and
// presents data FWFT through a head/skid buffer; reports level and almost-empty.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PTR_WIDTH   = DEF_PTR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic [PTR_WIDTH:0]     wr_ptr_gray,
    output logic [PTR_WIDTH:0]     rd_ptr_gray,
    output logic                   mem_rd_en,
    output logic [PTR_WIDTH-1:0]   mem_rd_addr,
    input  logic [WIDTH-1:0]       mem_rd_data,
    async_fifo_rd_ctrl_if.master   out_if,
    output logic [PTR_WIDTH+1:0]   rd_level,
    output logic                   almost_empty
);

    localparam int PW = PTR_WIDTH + 1;
    localparam int LW = PTR_WIDTH + 2;

    logic [PTR_WIDTH:0]   wr_gray_s;
    logic [PTR_WIDTH:0]   wr_bin_s;
    logic [PTR_WIDTH:0]   rd_ptr_bin;
    logic [PTR_WIDTH:0]   rd_ptr_bin_nxt;
    logic [PTR_WIDTH:0]   mem_words;
    logic [LW-1:0]        level_nxt;

    logic                 inflight;
    logic                 head_valid;
    logic                 skid_valid;
    logic [WIDTH-1:0]     head_data;
    logic [WIDTH-1:0]     skid_data;

    logic [1:0]           occ;
    logic [2:0]           demand;
    logic                 pop;
    logic                 mem_empty;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_ptr_gray),
        .q   (wr_gray_s)
    );

    assign wr_bin_s  = PW'(gray2bin(32'(wr_gray_s)));
    assign mem_empty = (rd_ptr_bin == wr_bin_s);

    assign occ    = 2'(head_valid) + 2'(skid_valid);
    assign pop    = head_valid && out_if.out_ready;
    // Words that will occupy the buffer once the outstanding read lands; never exceeds 2.
    assign demand = 3'(occ) + 3'(inflight) - 3'(pop);

    assign mem_rd_en      = !mem_empty && (demand < 3'd2);
    assign mem_rd_addr    = rd_ptr_bin[PTR_WIDTH-1:0];
    assign rd_ptr_bin_nxt = rd_ptr_bin + PW'(1);

    assign mem_words = wr_bin_s - rd_ptr_bin;
    assign level_nxt = LW'(mem_words) + LW'(occ) + LW'(inflight);

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                rd_ptr_bin  <= rd_ptr_bin_nxt;
                rd_ptr_gray <= PW'(bin2gray(32'(rd_ptr_bin_nxt)));
            end
        end
    end

    // A landing word goes to the head when the head is free or draining with an empty skid;
    // otherwise it waits in the skid, which always refills the head first to keep order.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                head_data <= skid_data;
                if (inflight) begin
                    skid_data <= mem_rd_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (inflight) begin
                head_data <= mem_rd_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (inflight) begin
            if (!head_valid) begin
                head_data  <= mem_rd_data;
                head_valid <= 1'b1;
            end else begin
                skid_data  <= mem_rd_data;
                skid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_level     <= level_nxt;
            almost_empty <= (level_nxt <= LW'(AE_THRESH));
        end
    end

    assign out_if.out_data  = head_data;
    assign out_if.out_valid = head_valid;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl with a synchronous-read memory and writer model.
module tb_async_fifo_rd_ctrl;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b0;
    logic [4:0]  wr_ptr_gray = '0;
    logic [4:0]  rd_ptr_gray;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data = '0;
    logic [5:0]  rd_level;
    logic        almost_empty;

    logic [15:0] mem [16];
    int total = 0;
    int bad   = 0;

    async_fifo_rd_ctrl_if #(.WIDTH(16)) out_if ();

    async_fifo_rd_ctrl #(
        .WIDTH       (16),
        .PTR_WIDTH   (4),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .out_if       (out_if),
        .rd_level     (rd_level),
        .almost_empty (almost_empty)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rd_rst = 1'b0;
        wr_ptr_gray = '0;
        out_if.out_ready = 1'b0;
        tick();
        tick();
        rd_rst = 1'b1;
        tick();
    endtask

    initial begin
        int nreads;
        int del;
        int wr_cnt;
        int nchg;
        logic [4:0] prev;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset with random consumer activity
        rd_rst = 1'b0;
        out_if.out_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            tick();
            out_if.out_ready = 1'($urandom_range(0, 1));
        end
        chk("rst_valid", 32'(out_if.out_valid), 0);
        chk("rst_rden", 32'(mem_rd_en), 0);
        chk("rst_gray", 32'(rd_ptr_gray), 0);
        chk("rst_level", 32'(rd_level), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        rd_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_if.out_ready = 1'($urandom_range(0, 1));
            tick();
            chk("idle_valid", 32'(out_if.out_valid), 0);
            chk("idle_rden", 32'(mem_rd_en), 0);
            chk("idle_ae", 32'(almost_empty), 1);
        end

        // Single word: sampled at edge 1, issued at edge 3, head loaded 3 edges after sampling
        out_if.out_ready = 1'b0;
        mem[0] = 16'hA5A5;
        wr_ptr_gray = 5'd1;
        tick();
        chk("sw_rden_e1", 32'(mem_rd_en), 0);
        tick();
        chk("sw_rden_e2", 32'(mem_rd_en), 1);
        chk("sw_addr", 32'(mem_rd_addr), 0);
        chk("sw_valid_e2", 32'(out_if.out_valid), 0);
        tick();
        chk("sw_rden_e3", 32'(mem_rd_en), 0);
        chk("sw_valid_e3", 32'(out_if.out_valid), 0);
        chk("sw_gray", 32'(rd_ptr_gray), 1);
        tick();
        chk("sw_valid", 32'(out_if.out_valid), 1);
        chk("sw_data", 32'(out_if.out_data), 32'hA5A5);
        chk("sw_level", 32'(rd_level), 1);
        out_if.out_ready = 1'b1;
        tick();
        chk("sw_popped", 32'(out_if.out_valid), 0);
        out_if.out_ready = 1'b0;
        tick();
        tick();
        chk("sw_no_more", 32'(mem_rd_en), 0);
        chk("sw_still_empty", 32'(out_if.out_valid), 0);
        chk("sw_level_0", 32'(rd_level), 0);
        chk("sw_gray_hold", 32'(rd_ptr_gray), 1);

        // Backpressure: only two words leave memory, then drain without bubbles
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
        wr_ptr_gray = g(5'd4);
        nreads = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en) begin
                chk("bp_addr", 32'(mem_rd_addr), 32'(nreads));
                nreads++;
            end
            tick();
        end
        chk("bp_reads", 32'(nreads), 2);
        chk("bp_gray", 32'(rd_ptr_gray), 3);
        chk("bp_level", 32'(rd_level), 4);
        chk("bp_ae", 32'(almost_empty), 0);
        chk("bp_head", 32'(out_if.out_data), 32'h1000);
        out_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_stream_valid", 32'(out_if.out_valid), 1);
            chk("bp_stream_data", 32'(out_if.out_data), 32'h1000 + 32'(k));
            tick();
        end
        out_if.out_ready = 1'b0;
        chk("bp_drained", 32'(out_if.out_valid), 0);

        // Wrap: 40 words through a 16-deep memory, pointer passes 31 -> 0
        do_reset();
        out_if.out_ready = 1'b1;
        wr_cnt = 0;
        del = 0;
        nchg = 0;
        prev = rd_ptr_gray;
        for (int cyc = 0; cyc < 400 && del < 40; cyc++) begin
            if (out_if.out_valid) begin
                chk("wrap_data", 32'(out_if.out_data), 32'hC000 + 32'(del));
                del++;
            end
            if (wr_cnt < 40 && (wr_cnt - del) < 8) begin
                mem[wr_cnt % 16] = 16'hC000 + 16'(wr_cnt);
                wr_cnt++;
                wr_ptr_gray = g(5'(wr_cnt));
            end
            tick();
            if (rd_ptr_gray !== prev) begin
                chk("wrap_gray_1bit", 32'($countones(rd_ptr_gray ^ prev)), 1);
                prev = rd_ptr_gray;
                nchg++;
            end
        end
        chk("wrap_count", 32'(del), 40);
        chk("wrap_gray_changes", 32'(nchg), 40);
        chk("wrap_gray_end", 32'(rd_ptr_gray), 12);
        out_if.out_ready = 1'b0;

        // Reset mid-operation with a head word and a read in flight
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 16'h4000 + 16'(i);
        wr_ptr_gray = g(5'd5);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_pre_valid", 32'(out_if.out_valid), 1);
        chk("mid_pre_data", 32'(out_if.out_data), 32'h4000);
        for (int i = 0; i < 5; i++) mem[i] = 16'h5000 + 16'(i);
        #2;
        rd_rst = 1'b0;
        #1;
        chk("mid_valid_drop", 32'(out_if.out_valid), 0);
        chk("mid_rden", 32'(mem_rd_en), 0);
        chk("mid_gray", 32'(rd_ptr_gray), 0);
        chk("mid_level", 32'(rd_level), 0);
        chk("mid_ae", 32'(almost_empty), 1);
        tick();
        tick();
        rd_rst = 1'b1;
        out_if.out_ready = 1'b1;
        nreads = 0;
        del = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd_en) begin
                chk("mid_addr", 32'(mem_rd_addr), 32'(nreads));
                nreads++;
            end
            if (out_if.out_valid) begin
                chk("mid_data", 32'(out_if.out_data), 32'h5000 + 32'(del));
                del++;
            end
            tick();
        end
        chk("mid_reads", 32'(nreads), 5);
        chk("mid_delivered", 32'(del), 5);

        // Almost-empty threshold crossing in both directions
        do_reset();
        for (int i = 0; i < 3; i++) mem[i] = 16'h7000 + 16'(i);
        wr_ptr_gray = g(5'd3);
        for (int i = 0; i < 8; i++) tick();
        chk("ae_level3", 32'(rd_level), 3);
        chk("ae_off3", 32'(almost_empty), 0);
        chk("ae_head0", 32'(out_if.out_data), 32'h7000);
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
        chk("ae_lag_level", 32'(rd_level), 3);
        chk("ae_lag_flag", 32'(almost_empty), 0);
        chk("ae_head1", 32'(out_if.out_data), 32'h7001);
        tick();
        chk("ae_level2", 32'(rd_level), 2);
        chk("ae_on2", 32'(almost_empty), 1);
        mem[3] = 16'h7003;
        wr_ptr_gray = g(5'd4);
        tick();
        chk("ae_sync1_flag", 32'(almost_empty), 1);
        chk("ae_sync1_level", 32'(rd_level), 2);
        tick();
        chk("ae_sync2_flag", 32'(almost_empty), 1);
        tick();
        chk("ae_rise_flag", 32'(almost_empty), 0);
        chk("ae_rise_level", 32'(rd_level), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
